dac_play_sequencer: RTL
=======================

Name: dac_play_sequencer

Overview:
- Schedules playback for the dual-channel DAC sample memory.
- Latches the per-channel loop lengths at arm time. Waits for an immediate or external start, then drives the per-channel enable/length inputs of the DAC continuous-generation controller.
- Counts completed loops and stops after a programmed repeat count, raising a done pulse.
- Sits between the CSR block and the DAC memory controller in the 65 MHz domain.

Parameters:
- ADDR_WIDTH, 11, sample address / loop-length width; matches DAC BRAM depth.
- REP_WIDTH, 16, repeat-count and loop-counter width.

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  synchronous reset, active-high
- csr_arm_i  in  1  one-cycle pulse: latch config and arm
- csr_abort_i  in  1  one-cycle pulse: stop immediately
- csr_ch_mask_i  in  2  bit0 = channel 0 enabled, bit1 = channel 1 enabled
- csr_len0_i  in  ADDR_WIDTH  channel 0 loop length (samples)
- csr_len1_i  in  ADDR_WIDTH  channel 1 loop length (samples)
- csr_repeat_i  in  REP_WIDTH  loops to play; 0 = infinite
- csr_trig_mode_i  in  1  0 = start on arm, 1 = start on trig_i rising edge
- trig_i  in  1  external trigger, already synchronous to clk
- dac_en0_o  out  1  to controller channel 0 enable
- dac_en1_o  out  1  to controller channel 1 enable
- dac_len0_o  out  ADDR_WIDTH  latched channel 0 length
- dac_len1_o  out  ADDR_WIDTH  latched channel 1 length
- busy_o  out  1  high in ARMED or RUN
- done_o  out  1  one-cycle pulse on normal completion
- cfg_err_o  out  1  one-cycle pulse: arm rejected
- loops_done_o  out  REP_WIDTH  completed loops in current/last run; saturates at all-ones

Behaviour:
- Reset values:
  - state IDLE
  - all outputs 0, including dac_len*_o and loops_done_o
  - trig_i edge-detect register 0
- States: IDLE, ARMED, RUN. All outputs are registered.
- IDLE, on csr_arm_i:
  - Rejected if mask == 0, or if any enabled channel has len == 0. Reject means: cfg_err_o pulses the next cycle; stay IDLE.
  - Otherwise latch mask, len0, len1, repeat and trig_mode into shadow registers; clear loops_done_o.
  - Trig_mode 0: go to RUN.
  - Trig_mode 1: go to ARMED.
- dac_len*_o reflect the shadow registers only. CSR length changes while busy have no effect.
- ARMED:
  - Wait for a trig_i rising edge (trig_i = 1 while its registered copy = 0), then go to RUN.
  - Trigger edges outside ARMED are ignored.
- RUN:
  - dac_en*_o = shadow mask bits; asserted from the first RUN cycle.
  - Master channel is ch0 if mask[0], else ch1; master length = L.
  - Phase counter: 0 on the first RUN cycle, +1 per cycle, wraps L-1 -> 0.
  - Each wrap increments the loop counter and loops_done_o.
  - Termination, repeat != 0: the cycle after the wrap that makes loops == repeat, go to IDLE with dac_en*_o = 0 and done_o = 1 for one cycle.
  - Result: enables are high for exactly repeat*L cycles, so the controller emits exactly repeat*L samples per master channel.
  - Repeat == 0: run until abort. The loop counter saturates and does not wrap.
- csr_abort_i in any state:
  - Go to IDLE next cycle; dac_en*_o = 0; no done_o.
  - loops_done_o holds its last value.
- Priority in the same cycle:
  - abort > arm
  - abort > trigger
  - abort > final wrap (no done)
- csr_arm_i while busy is ignored: no error, no relatch.
- The non-master channel runs free at its own length in the controller. The sequencer does not count its loops.
- Reset mid-run: next cycle everything returns to reset values.

Decomposition:
- signal_types_pkg gains:
  - seq_state_t enum (IDLE/ARMED/RUN)
  - dac_seq_cfg_t struct (mask, len0, len1, repeat, trig_mode)
- Sub-module: dac_seq_loop_counter. Holds the phase counter, wrap detect, and saturating loop counter. Inputs: clear, run, L. Outputs: wrap, loops. The FSM stays in the top.

Test Plan:
- Immediate 3 loops: mask=01, len0=4, repeat=3, trig_mode=0, arm -> dac_en0_o high exactly 12 cycles starting the cycle after arm; done_o one pulse on cycle 13; loops_done_o=3; dac_en1_o stays 0.
- External trigger: mask=11, len0=5, len1=7, repeat=2, trig_mode=1, arm then trig_i rises 20 cycles later -> busy_o high from the cycle after arm; both enables high 10 cycles beginning the cycle after the trigger edge; master = ch0.
- Config errors: arm with mask=00, then with mask=10 and len1=0 -> cfg_err_o pulses each time; busy_o stays 0; dac_len*_o unchanged.
- Abort during RUN: repeat=0, len0=8, abort at cycle 30 -> enables 0 next cycle; no done_o; loops_done_o=3; re-arm works normally.
- Relatch protection: change csr_len0_i from 4 to 9 mid-run, and pulse csr_arm_i while busy -> dac_len0_o stays 4; run length unchanged; no cfg_err_o.
- Simultaneous events: abort together with a trigger edge in ARMED -> IDLE, no RUN. Abort on the final-wrap cycle -> no done_o. Synchronous rst mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/dac_play_sequencer_pkg.sv
// Shared types and widths for the DAC playback sequencer.
package dac_play_sequencer_pkg;

    localparam int DAC_ADDR_W = 11;   // sample address / loop-length width (BRAM depth)
    localparam int DAC_REP_W  = 16;   // repeat count and loop counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Configuration captured at arm time; nothing downstream sees live CSR values.
    typedef struct packed {
        logic [1:0]            mask;
        logic [DAC_ADDR_W-1:0] len0;
        logic [DAC_ADDR_W-1:0] len1;
        logic [DAC_REP_W-1:0]  rep;
        logic                  trig_mode;
    } dac_seq_cfg_t;

    // An arm request is valid when at least one channel is on and every
    // enabled channel has a non-zero loop length.
    function automatic logic cfg_valid(input logic [1:0] mask,
                                       input logic [DAC_ADDR_W-1:0] len0,
                                       input logic [DAC_ADDR_W-1:0] len1);
        return (mask != 2'b00) &&
               !(mask[0] && (len0 == '0)) &&
               !(mask[1] && (len1 == '0));
    endfunction

endpackage

// File: rtl/dac_play_sequencer_if.sv
// CSR-side controls and DAC-controller-side outputs of the playback sequencer.
interface dac_play_sequencer_if
    import dac_play_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DAC_ADDR_W,
    parameter int REP_WIDTH  = DAC_REP_W
);
    logic                  csr_arm_i;
    logic                  csr_abort_i;
    logic [1:0]            csr_ch_mask_i;
    logic [ADDR_WIDTH-1:0] csr_len0_i;
    logic [ADDR_WIDTH-1:0] csr_len1_i;
    logic [REP_WIDTH-1:0]  csr_repeat_i;
    logic                  csr_trig_mode_i;
    logic                  trig_i;
    logic                  dac_en0_o;
    logic                  dac_en1_o;
    logic [ADDR_WIDTH-1:0] dac_len0_o;
    logic [ADDR_WIDTH-1:0] dac_len1_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  cfg_err_o;
    logic [REP_WIDTH-1:0]  loops_done_o;

    // CSR block / trigger source side
    modport master (
        output csr_arm_i, csr_abort_i, csr_ch_mask_i, csr_len0_i, csr_len1_i,
               csr_repeat_i, csr_trig_mode_i, trig_i,
        input  dac_en0_o, dac_en1_o, dac_len0_o, dac_len1_o, busy_o, done_o,
               cfg_err_o, loops_done_o
    );

    // Sequencer side
    modport slave (
        input  csr_arm_i, csr_abort_i, csr_ch_mask_i, csr_len0_i, csr_len1_i,
               csr_repeat_i, csr_trig_mode_i, trig_i,
        output dac_en0_o, dac_en1_o, dac_len0_o, dac_len1_o, busy_o, done_o,
               cfg_err_o, loops_done_o
    );
endinterface

// File: rtl/dac_play_sequencer_loop_counter.sv
// Master-channel phase counter with wrap detect and saturating loop count.
module dac_seq_loop_counter #(
    parameter int ADDR_WIDTH = 11,
    parameter int REP_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  wrap,
    output logic [REP_WIDTH-1:0]  loops
);
    logic [ADDR_WIDTH-1:0] phase;

    // Last sample of a master loop; len is never 0 while run is high.
    assign wrap = run && (phase == len - ADDR_WIDTH'(1));

    // Phase sits at 0 outside RUN so the first RUN cycle is phase 0;
    // the loop count only moves on wraps and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            loops <= '0;
        end else begin
            phase <= (run && !wrap) ? phase + ADDR_WIDTH'(1) : '0;
            if (clear)
                loops <= '0;
            else if (wrap && (loops != '1))
                loops <= loops + REP_WIDTH'(1);
        end
    end
endmodule

// File: rtl/dac_play_sequencer.sv
// Playback scheduler: latches config on arm, starts on arm or trigger edge,
// gates the DAC controller enables for repeat*L master samples.
module dac_play_sequencer
    import dac_play_sequencer_pkg::*;
#(
    // Widths must match the package widths used by dac_seq_cfg_t.
    parameter int ADDR_WIDTH = DAC_ADDR_W,
    parameter int REP_WIDTH  = DAC_REP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    dac_play_sequencer_if.slave  bus
);
    seq_state_t            state;
    dac_seq_cfg_t          cfg;
    logic                  trig_q;
    logic                  en0, en1, busy, done, cfg_err;
    logic                  wrap;
    logic [REP_WIDTH-1:0]  loops;
    logic [ADDR_WIDTH-1:0] master_len;
    logic                  trig_edge, arm_ok, accept, last_wrap, cnt_run;

    assign trig_edge  = bus.trig_i && !trig_q;
    assign arm_ok     = cfg_valid(bus.csr_ch_mask_i, bus.csr_len0_i, bus.csr_len1_i);
    assign accept     = (state == IDLE) && bus.csr_arm_i && !bus.csr_abort_i && arm_ok;
    assign master_len = cfg.mask[0] ? cfg.len0 : cfg.len1;
    // Abort wins over a wrap in the same cycle, so the count holds its value.
    assign cnt_run    = (state == RUN) && !bus.csr_abort_i;
    assign last_wrap  = wrap && (cfg.rep != '0) && (loops == cfg.rep - REP_WIDTH'(1));

    dac_seq_loop_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REP_WIDTH  (REP_WIDTH)
    ) u_loop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .run   (cnt_run),
        .len   (master_len),
        .wrap  (wrap),
        .loops (loops)
    );

    // Sequencer FSM with registered enables and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cfg     <= '0;
            trig_q  <= 1'b0;
            en0     <= 1'b0;
            en1     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            trig_q  <= bus.trig_i;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (bus.csr_abort_i) begin
                state <= IDLE;
                en0   <= 1'b0;
                en1   <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.csr_arm_i) begin
                            if (!arm_ok) begin
                                cfg_err <= 1'b1;
                            end else begin
                                cfg.mask      <= bus.csr_ch_mask_i;
                                cfg.len0      <= bus.csr_len0_i;
                                cfg.len1      <= bus.csr_len1_i;
                                cfg.rep       <= bus.csr_repeat_i;
                                cfg.trig_mode <= bus.csr_trig_mode_i;
                                busy          <= 1'b1;
                                if (bus.csr_trig_mode_i) begin
                                    state <= ARMED;
                                end else begin
                                    state <= RUN;
                                    en0   <= bus.csr_ch_mask_i[0];
                                    en1   <= bus.csr_ch_mask_i[1];
                                end
                            end
                        end
                    end
                    ARMED: begin
                        if (trig_edge) begin
                            state <= RUN;
                            en0   <= cfg.mask[0];
                            en1   <= cfg.mask[1];
                        end
                    end
                    RUN: begin
                        if (last_wrap) begin
                            state <= IDLE;
                            en0   <= 1'b0;
                            en1   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dac_en0_o    = en0;
    assign bus.dac_en1_o    = en1;
    assign bus.dac_len0_o   = cfg.len0;
    assign bus.dac_len1_o   = cfg.len1;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.cfg_err_o    = cfg_err;
    assign bus.loops_done_o = loops;
endmodule
